// File: rtl/pe_core.sv
// ---------------------------------------------------------------------------
// pe_core -- pixel processing element
//
// Two operations on a pixel given as three channel vectors:
//   * channel sum: clears the red/green/blue sums, then adds the incoming
//     channel values with saturation at 2^W-1.
//   * background removal: computes per-channel |in - exp|. If every
//     difference is within threshold, the pixel is treated as background and
//     replaced by the desired background colour. Otherwise the incoming pixel
//     is passed through unchanged.
//
// Ports
//   Clk                           single clock, rising edge
//   Reset                         synchronous, active-low
//   Ack                           level acknowledge, returns done states to idle
//   Start_Sum, Start_BgRemoval    operation starts, sampled in idle only
//   red/green/blue_in       [W]   incoming pixel
//   red/green/blue_exp      [W]   expected background colour
//   threshold               [W]   per-channel match tolerance
//   desired_bg_r/g/b        [W]   replacement background colour
//   red/green/blue_out      [W]   registered processed pixel
//   red/green/blue_sum      [W]   registered channel sums
//   Qi..Qbgd                      one-hot state indicators
// ---------------------------------------------------------------------------
module pe_core #(
    parameter  int NUM_PIXELS = 1,
    localparam int W          = 8 * NUM_PIXELS + 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Ack,
    input  logic         Start_Sum,
    input  logic         Start_BgRemoval,
    input  logic [W-1:0] red_in,
    input  logic [W-1:0] green_in,
    input  logic [W-1:0] blue_in,
    input  logic [W-1:0] red_exp,
    input  logic [W-1:0] green_exp,
    input  logic [W-1:0] blue_exp,
    input  logic [W-1:0] threshold,
    input  logic [W-1:0] desired_bg_r,
    input  logic [W-1:0] desired_bg_g,
    input  logic [W-1:0] desired_bg_b,
    output logic [W-1:0] red_out,
    output logic [W-1:0] green_out,
    output logic [W-1:0] blue_out,
    output logic [W-1:0] red_sum,
    output logic [W-1:0] green_sum,
    output logic [W-1:0] blue_sum,
    output logic         Qi,
    output logic         Qsi,
    output logic         Qs,
    output logic         Qsd,
    output logic         Qbgi,
    output logic         Qbg,
    output logic         Qbad,
    output logic         Qbgd
);

    typedef enum logic [2:0] {
        S_I   = 3'd0,
        S_SI  = 3'd1,
        S_S   = 3'd2,
        S_SD  = 3'd3,
        S_BGI = 3'd4,
        S_BG  = 3'd5,
        S_BAD = 3'd6,
        S_BGD = 3'd7
    } state_t;

    state_t state;
    state_t state_next;

    logic [W-1:0] diff_r;
    logic [W-1:0] diff_g;
    logic [W-1:0] diff_b;
    logic         is_bg;

    // Widen by one bit so the carry-out selects the saturated value.
    function automatic logic [W-1:0] sat_add(input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[W] ? {W{1'b1}} : s[W-1:0];
    endfunction

    // Subtract in the order that keeps the result non-negative, so no wrap.
    function automatic logic [W-1:0] abs_diff(input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // A difference equal to the threshold still counts as a match.
    assign is_bg = (diff_r <= threshold) && (diff_g <= threshold) &&
                   (diff_b <= threshold);

    always_comb begin
        state_next = state;
        case (state)
            S_I: begin
                // Sum wins when both starts arrive together.
                if (Start_Sum)
                    state_next = S_SI;
                else if (Start_BgRemoval)
                    state_next = S_BGI;
            end
            S_SI:  state_next = S_S;
            S_S:   state_next = S_SD;
            S_SD:  if (Ack) state_next = S_I;
            S_BGI: state_next = S_BG;
            S_BG:  state_next = is_bg ? S_BAD : S_BGD;
            S_BAD: state_next = S_BGD;
            S_BGD: if (Ack) state_next = S_I;
            default: state_next = S_I;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state     <= S_I;
            red_out   <= '0;
            green_out <= '0;
            blue_out  <= '0;
            red_sum   <= '0;
            green_sum <= '0;
            blue_sum  <= '0;
            diff_r    <= '0;
            diff_g    <= '0;
            diff_b    <= '0;
        end else begin
            state <= state_next;
            case (state)
                S_SI: begin
                    red_sum   <= '0;
                    green_sum <= '0;
                    blue_sum  <= '0;
                end
                S_S: begin
                    red_sum   <= sat_add(red_sum,   red_in);
                    green_sum <= sat_add(green_sum, green_in);
                    blue_sum  <= sat_add(blue_sum,  blue_in);
                end
                S_BGI: begin
                    diff_r    <= abs_diff(red_in,   red_exp);
                    diff_g    <= abs_diff(green_in, green_exp);
                    diff_b    <= abs_diff(blue_in,  blue_exp);
                    // Pass-through value; overwritten later only on a match.
                    red_out   <= red_in;
                    green_out <= green_in;
                    blue_out  <= blue_in;
                end
                S_BAD: begin
                    red_out   <= desired_bg_r;
                    green_out <= desired_bg_g;
                    blue_out  <= desired_bg_b;
                end
                default: ;
            endcase
        end
    end

    assign Qi   = (state == S_I);
    assign Qsi  = (state == S_SI);
    assign Qs   = (state == S_S);
    assign Qsd  = (state == S_SD);
    assign Qbgi = (state == S_BGI);
    assign Qbg  = (state == S_BG);
    assign Qbad = (state == S_BAD);
    assign Qbgd = (state == S_BGD);

endmodule

// File: tb/tb_pe_core.sv
// ---------------------------------------------------------------------------
// tb_pe_core -- directed bench for pe_core at NUM_PIXELS=1 (W=9).
// The driver keeps a behavioural model (expected state indicator, output
// pixel and sums) up to date after every clock edge. One compare process
// checks the DUT against that model on every falling edge. A few literal
// expectations pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_pe_core;

    localparam int W    = 9;
    localparam int MAXV = (1 << W) - 1;

    // One-hot order: {Qi,Qsi,Qs,Qsd,Qbgi,Qbg,Qbad,Qbgd}
    localparam logic [7:0] Q_I   = 8'b1000_0000;
    localparam logic [7:0] Q_SI  = 8'b0100_0000;
    localparam logic [7:0] Q_S   = 8'b0010_0000;
    localparam logic [7:0] Q_SD  = 8'b0001_0000;
    localparam logic [7:0] Q_BGI = 8'b0000_1000;
    localparam logic [7:0] Q_BG  = 8'b0000_0100;
    localparam logic [7:0] Q_BAD = 8'b0000_0010;
    localparam logic [7:0] Q_BGD = 8'b0000_0001;

    logic         Clk;
    logic         Reset;
    logic         Ack;
    logic         Start_Sum;
    logic         Start_BgRemoval;
    logic [W-1:0] red_in, green_in, blue_in;
    logic [W-1:0] red_exp, green_exp, blue_exp;
    logic [W-1:0] threshold;
    logic [W-1:0] desired_bg_r, desired_bg_g, desired_bg_b;
    logic [W-1:0] red_out, green_out, blue_out;
    logic [W-1:0] red_sum, green_sum, blue_sum;
    logic         Qi, Qsi, Qs, Qsd, Qbgi, Qbg, Qbad, Qbgd;

    pe_core #(.NUM_PIXELS(1)) dut (
        .Clk             (Clk),
        .Reset           (Reset),
        .Ack             (Ack),
        .Start_Sum       (Start_Sum),
        .Start_BgRemoval (Start_BgRemoval),
        .red_in          (red_in),
        .green_in        (green_in),
        .blue_in         (blue_in),
        .red_exp         (red_exp),
        .green_exp       (green_exp),
        .blue_exp        (blue_exp),
        .threshold       (threshold),
        .desired_bg_r    (desired_bg_r),
        .desired_bg_g    (desired_bg_g),
        .desired_bg_b    (desired_bg_b),
        .red_out         (red_out),
        .green_out       (green_out),
        .blue_out        (blue_out),
        .red_sum         (red_sum),
        .green_sum       (green_sum),
        .blue_sum        (blue_sum),
        .Qi              (Qi),
        .Qsi             (Qsi),
        .Qs              (Qs),
        .Qsd             (Qsd),
        .Qbgi            (Qbgi),
        .Qbg             (Qbg),
        .Qbad            (Qbad),
        .Qbgd            (Qbgd)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en   = 1'b0;

    logic [7:0]   m_q;
    logic [W-1:0] m_out_r, m_out_g, m_out_b;
    logic [W-1:0] m_sum_r, m_sum_g, m_sum_b;

    logic [7:0] qvec;
    assign qvec = {Qi, Qsi, Qs, Qsd, Qbgi, Qbg, Qbad, Qbgd};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int sat(input int a, input int b);
        return (a + b > MAXV) ? MAXV : a + b;
    endfunction

    function automatic bit bg_match(input int ir, input int ig, input int ib,
                                    input int er, input int eg, input int eb,
                                    input int th);
        return (iabs(ir - er) <= th) && (iabs(ig - eg) <= th) &&
               (iabs(ib - eb) <= th);
    endfunction

    always @(negedge Clk) begin
        if (chk_en) begin
            chk("state", {56'd0, qvec}, {56'd0, m_q});
            chk("onehot", {63'd0, $onehot(qvec)}, 64'd1);
            chk("out", {37'd0, red_out, green_out, blue_out},
                {37'd0, m_out_r, m_out_g, m_out_b});
            chk("sum", {37'd0, red_sum, green_sum, blue_sum},
                {37'd0, m_sum_r, m_sum_g, m_sum_b});
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Sum operation. ack_wait = 0: Ack raised right after the start pulse.
    // Otherwise Ack stays low for ack_wait cycles in the done state.
    task automatic run_sum(input int r, input int g, input int b,
                           input bit also_bg, input bit bg_during_s,
                           input int ack_wait);
        red_in = W'(r); green_in = W'(g); blue_in = W'(b);
        Start_Sum = 1'b1;
        Start_BgRemoval = also_bg;
        tick();
        m_q = Q_SI;
        Start_Sum = 1'b0;
        Start_BgRemoval = 1'b0;
        Ack = (ack_wait == 0);
        tick();
        m_q = Q_S;
        m_sum_r = '0; m_sum_g = '0; m_sum_b = '0;
        Start_BgRemoval = bg_during_s;
        tick();
        m_q = Q_SD;
        m_sum_r = W'(sat(0, r)); m_sum_g = W'(sat(0, g)); m_sum_b = W'(sat(0, b));
        Start_BgRemoval = 1'b0;
        for (int i = 0; i < ack_wait; i++) begin
            tick();
            m_q = Q_SD;
        end
        Ack = 1'b1;
        tick();
        m_q = Q_I;
        Ack = 1'b0;
    endtask

    task automatic run_bg(input int ir, input int ig, input int ib,
                          input int er, input int eg, input int eb,
                          input int th, input int dr, input int dg, input int db,
                          input bit ack_hold);
        bit match;
        red_in = W'(ir); green_in = W'(ig); blue_in = W'(ib);
        red_exp = W'(er); green_exp = W'(eg); blue_exp = W'(eb);
        threshold = W'(th);
        desired_bg_r = W'(dr); desired_bg_g = W'(dg); desired_bg_b = W'(db);
        match = bg_match(ir, ig, ib, er, eg, eb, th);
        Start_BgRemoval = 1'b1;
        Ack = ack_hold;
        tick();
        m_q = Q_BGI;
        Start_BgRemoval = 1'b0;
        tick();
        m_q = Q_BG;
        m_out_r = W'(ir); m_out_g = W'(ig); m_out_b = W'(ib);
        tick();
        m_q = match ? Q_BAD : Q_BGD;
        if (match) begin
            tick();
            m_q = Q_BGD;
            m_out_r = W'(dr); m_out_g = W'(dg); m_out_b = W'(db);
        end
        if (!ack_hold) begin
            tick();
            m_q = Q_BGD;
            Ack = 1'b1;
        end
        tick();
        m_q = Q_I;
        Ack = 1'b0;
    endtask

    initial begin
        Reset = 1'b0; Ack = 1'b0; Start_Sum = 1'b0; Start_BgRemoval = 1'b0;
        red_in = 9'd7; green_in = 9'd8; blue_in = 9'd9;
        red_exp = '0; green_exp = '0; blue_exp = '0; threshold = '0;
        desired_bg_r = '0; desired_bg_g = '0; desired_bg_b = '0;
        m_q = Q_I;
        m_out_r = '0; m_out_g = '0; m_out_b = '0;
        m_sum_r = '0; m_sum_g = '0; m_sum_b = '0;

        // Reset held low for five cycles
        tick();
        chk_en = 1'b1;
        repeat (4) tick();
        chk("rst_q_lit", {56'd0, qvec}, 64'h80);
        chk("rst_out_lit", {37'd0, red_out, green_out, blue_out}, 64'd0);
        chk("rst_sum_lit", {37'd0, red_sum, green_sum, blue_sum}, 64'd0);
        Reset = 1'b1;

        // Basic sum with Ack raised the cycle after the start
        run_sum(61, 133, 198, 1'b0, 1'b0, 0);
        chk("sum_lit", {37'd0, red_sum, green_sum, blue_sum},
            {37'd0, 9'd61, 9'd133, 9'd198});
        tick();
        m_q = Q_I;

        // Exact background match with Ack held high throughout
        run_bg(61, 133, 198, 61, 133, 198, 30, 10, 10, 10, 1'b1);
        chk("bg_match_lit", {37'd0, red_out, green_out, blue_out},
            {37'd0, 9'd10, 9'd10, 9'd10});
        chk("sum_retained_lit", {37'd0, red_sum, green_sum, blue_sum},
            {37'd0, 9'd61, 9'd133, 9'd198});
        tick();
        m_q = Q_I;

        // Blue diff 31 exceeds the threshold: pixel passes through
        run_bg(61, 133, 198, 61, 133, 229, 30, 10, 10, 10, 1'b0);
        chk("bg_nomatch_lit", {37'd0, red_out, green_out, blue_out},
            {37'd0, 9'd61, 9'd133, 9'd198});

        // Blue diff exactly 30: match
        run_bg(61, 133, 198, 61, 133, 228, 30, 10, 10, 10, 1'b1);
        chk("bg_edge_lit", {37'd0, red_out, green_out, blue_out},
            {37'd0, 9'd10, 9'd10, 9'd10});

        // in above exp in red, below in green, within tolerance
        run_bg(100, 40, 511, 70, 60, 500, 30, 1, 2, 3, 1'b0);
        chk("bg_mixed_lit", {37'd0, red_out, green_out, blue_out},
            {37'd0, 9'd1, 9'd2, 9'd3});

        // Zero threshold, off by one in green: no match
        run_bg(5, 6, 7, 5, 7, 7, 0, 9, 9, 9, 1'b1);
        chk("bg_zero_th_lit", {37'd0, red_out, green_out, blue_out},
            {37'd0, 9'd5, 9'd6, 9'd7});

        // Ack in idle has no effect
        Ack = 1'b1;
        tick();
        m_q = Q_I;
        Ack = 1'b0;

        // Both starts together take the sum path. A bg start during the
        // sum is ignored, and Ack low keeps the done state for three cycles.
        run_sum(1, 2, 3, 1'b1, 1'b1, 3);
        chk("prio_sum_lit", {37'd0, red_sum, green_sum, blue_sum},
            {37'd0, 9'd1, 9'd2, 9'd3});
        chk("prio_out_lit", {37'd0, red_out, green_out, blue_out},
            {37'd0, 9'd5, 9'd6, 9'd7});

        // Reset asserted while comparing aborts the operation
        red_in = 9'd50; green_in = 9'd60; blue_in = 9'd70;
        red_exp = 9'd50; green_exp = 9'd60; blue_exp = 9'd70;
        threshold = 9'd3;
        Start_BgRemoval = 1'b1;
        tick();
        m_q = Q_BGI;
        Start_BgRemoval = 1'b0;
        tick();
        m_q = Q_BG;
        m_out_r = 9'd50; m_out_g = 9'd60; m_out_b = 9'd70;
        Reset = 1'b0;
        tick();
        m_q = Q_I;
        m_out_r = '0; m_out_g = '0; m_out_b = '0;
        m_sum_r = '0; m_sum_g = '0; m_sum_b = '0;
        chk("mid_rst_lit", {28'd0, qvec, red_out, green_out, blue_out},
            {28'd0, 8'h80, 27'd0});

        // Start accepted in the first cycle sampling Reset high
        Reset = 1'b1;
        run_sum(200, 0, 511, 1'b0, 1'b0, 0);
        chk("post_rst_sum_lit", {37'd0, red_sum, green_sum, blue_sum},
            {37'd0, 9'd200, 9'd0, 9'd511});

        repeat (2) tick();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
